fetch_queue: RTL and testbench

Instruction prefetch buffer directly upstream of the dual-issue decode/execute stage. Fetches 64-bit two-instruction bundles from a synchronous-read instruction RAM, buffers up to DEPTH bundles, and hands them downstream with valid/ready. A redirect (taken branch, jal, jalr) flushes all buffered and in-flight bundles and restarts fetch at the new PC.

---
 rtl/fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_fetch_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction prefetch buffer feeding the dual-issue decode stage.
//
// Fetches 64-bit two-instruction bundles from a synchronous-read instruction
// RAM, buffers up to DEPTH of them and presents the head bundle downstream
// with valid/ready. A redirect flushes every buffered and in-flight bundle
// and restarts fetch at the new PC.
//
// Parameters:
//   DEPTH    bundle entries (power of two, 2..16)
//   PC_W     PC width in 32-bit instruction units
//   RESET_PC fetch PC after reset (bit 0 forced to 0)
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   redirect_valid/redirect_pc flush and restart fetch at redirect_pc (bit 0 ignored)
//   mem_en/mem_addr            instruction RAM read strobe and bundle index
//   mem_rdata                  bundle returned the cycle after mem_en
//                              ([63:32] slot 1 = lower address, [31:0] slot 2)
//   out_valid/out_ready        downstream handshake
//   out_bundle/out_pc          head bundle and PC of its slot 1 (0 while empty)
//   count                      buffered bundles, excluding the in-flight read
//
// Optional feature (macro FETCHQ_STATS_EN):
//   stat_bundles  saturating count of accepted downstream handshakes
//   stat_kills    saturating count of discarded in-flight responses plus
//                 buffered bundles dropped by a flush
module fetch_queue #(
   parameter int              DEPTH    = 4,
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         redirect_valid,
   input  logic [PC_W-1:0]              redirect_pc,
   output logic                         mem_en,
   output logic [PC_W-2:0]              mem_addr,
   input  logic [63:0]                  mem_rdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [63:0]                  out_bundle,
   output logic [PC_W-1:0]              out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FETCHQ_STATS_EN
   ,
   output logic [15:0]                  stat_bundles,
   output logic [15:0]                  stat_kills
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PC_W-1:0] EVEN_MASK = {{(PC_W-1){1'b1}}, 1'b0};

   // Control state
   logic              run_reg;          // low until the first edge after reset release
   logic [PC_W-1:0]   fetch_pc_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              inflight_reg;     // a read was issued last cycle
   logic [PC_W-1:0]   inflight_pc_reg;

   // Bundle storage
   logic [63:0]       fifo_data [DEPTH];
   logic [PC_W-1:0]   fifo_pc   [DEPTH];

   logic issue;
   logic push;
   logic pop;

   // The in-flight read is reserved a slot up front, so a captured response
   // always has room. A pop in the same cycle is deliberately not credited,
   // which keeps mem_en independent of out_ready.
   assign issue = run_reg && !redirect_valid &&
                  ((int'(count_reg) + int'(inflight_reg)) < DEPTH);

   // A response arriving in a redirect cycle belongs to the old stream; the
   // flush and the discard happen at the same edge, so no separate kill
   // bookkeeping is needed beyond suppressing the push.
   assign push = inflight_reg && !redirect_valid;
   assign pop  = out_valid && out_ready;

   assign mem_en     = issue;
   assign mem_addr   = fetch_pc_reg[PC_W-1:1];
   assign out_valid  = (count_reg != '0);
   // Gated so the head reads as zero while empty (including during reset)
   // without having to reset the storage array.
   assign out_bundle = out_valid ? fifo_data[rd_ptr_reg] : 64'd0;
   assign out_pc     = out_valid ? fifo_pc[rd_ptr_reg]   : '0;
   assign count      = count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_reg         <= 1'b0;
         fetch_pc_reg    <= RESET_PC & EVEN_MASK;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         count_reg       <= '0;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
      end else begin
         run_reg <= 1'b1;
         if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc & EVEN_MASK;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= 1'b0;
         end else begin
            inflight_reg <= issue;
            if (issue) begin
               fetch_pc_reg    <= fetch_pc_reg + PC_W'(2);
               inflight_pc_reg <= fetch_pc_reg;
            end
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push)
               wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
               count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push)
               count_reg <= count_reg - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr_reg] <= mem_rdata;
         fifo_pc[wr_ptr_reg]   <= inflight_pc_reg;
      end
   end

`ifdef FETCHQ_STATS_EN
   logic [15:0]      stat_bundles_reg;
   logic [15:0]      stat_kills_reg;
   logic [CNT_W:0]   kill_inc;
   logic [16:0]      bundles_sum;
   logic [16:0]      kills_sum;

   // A bundle popped in the redirect cycle is a completed transfer, not a
   // flushed one; pop implies count_reg >= 1 so this never underflows.
   assign kill_inc    = {1'b0, count_reg} - {{CNT_W{1'b0}}, pop}
                      + {{CNT_W{1'b0}}, inflight_reg};
   assign bundles_sum = {1'b0, stat_bundles_reg} + {16'd0, pop};
   assign kills_sum   = {1'b0, stat_kills_reg} + {{(16-CNT_W){1'b0}}, kill_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_bundles_reg <= '0;
         stat_kills_reg   <= '0;
      end else begin
         if (pop)
            stat_bundles_reg <= bundles_sum[16] ? 16'hFFFF : bundles_sum[15:0];
         if (redirect_valid)
            stat_kills_reg <= kills_sum[16] ? 16'hFFFF : kills_sum[15:0];
      end
   end

   assign stat_bundles = stat_bundles_reg;
   assign stat_kills   = stat_kills_reg;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- self-checking bench for fetch_queue (DEPTH=4, PC_W=10).
// Directed table and hand-written sequences run with RAM[i] = i; a final
// randomized phase compares the accepted stream against a PC-sequence model.
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam int PC_W  = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [9:0]  redirect_pc = '0;
   logic        mem_en;
   logic [8:0]  mem_addr;
   logic [63:0] mem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_bundle;
   logic [9:0]  out_pc;
   logic [2:0]  count;
`ifdef FETCHQ_STATS_EN
   logic [15:0] stat_bundles;
   logic [15:0] stat_kills;
`endif

   fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .RESET_PC(10'd0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_en         (mem_en),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_bundle     (out_bundle),
      .out_pc         (out_pc),
      .count          (count)
`ifdef FETCHQ_STATS_EN
      ,
      .stat_bundles   (stat_bundles),
      .stat_kills     (stat_kills)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction RAM
   logic [63:0] ram [512];
   always @(posedge clk)
      if (mem_en) mem_rdata <= ram[mem_addr];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Apply inputs just after a rising edge and settle to the falling edge.
   task automatic drive(input logic rdy, input logic rv, input logic [9:0] rpc);
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cycle(input string tag, input logic en, input logic [8:0] addr,
                            input logic v, input logic [9:0] pc, input logic [2:0] cnt);
      $display("%s: mem_en=%b mem_addr=%h out_valid=%b out_pc=%h out_bundle=%h count=%0d",
               tag, mem_en, mem_addr, out_valid, out_pc, out_bundle, count);
      chk({tag, "_mem_en"}, mem_en, en);
      if (en) chk({tag, "_mem_addr"}, mem_addr, addr);
      chk({tag, "_out_valid"}, out_valid, v);
      if (v) begin
         chk({tag, "_out_pc"}, out_pc, pc);
         chk({tag, "_out_bundle"}, out_bundle, {55'd0, pc[9:1]});
      end
      chk({tag, "_count"}, count, cnt);
   endtask

   // Assert reset off-edge, check the reset state, then release on a falling edge.
   task automatic do_reset();
      rst_n          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_count", count, 0);
      chk("rst_out_bundle", out_bundle, 0);
      chk("rst_out_pc", out_pc, 0);
`ifdef FETCHQ_STATS_EN
      chk("rst_stat_bundles", stat_bundles, 0);
      chk("rst_stat_kills", stat_kills, 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
   endtask

   typedef struct {
      logic       rdy;
      logic       en;
      logic [8:0] addr;
      logic       v;
      logic [9:0] pc;
      logic [2:0] cnt;
   } vec_t;

   vec_t stall_tab [11];

   initial begin
      // out_ready held low: four issues fill the buffer, then it drains in order.
      stall_tab[0]  = '{1'b0, 1'b1, 9'h000, 1'b0, 10'h000, 3'd0};
      stall_tab[1]  = '{1'b0, 1'b1, 9'h001, 1'b0, 10'h000, 3'd0};
      stall_tab[2]  = '{1'b0, 1'b1, 9'h002, 1'b1, 10'h000, 3'd1};
      stall_tab[3]  = '{1'b0, 1'b1, 9'h003, 1'b1, 10'h000, 3'd2};
      stall_tab[4]  = '{1'b0, 1'b0, 9'h000, 1'b1, 10'h000, 3'd3};
      stall_tab[5]  = '{1'b0, 1'b0, 9'h000, 1'b1, 10'h000, 3'd4};
      stall_tab[6]  = '{1'b1, 1'b0, 9'h000, 1'b1, 10'h000, 3'd4};
      stall_tab[7]  = '{1'b1, 1'b1, 9'h004, 1'b1, 10'h002, 3'd3};
      stall_tab[8]  = '{1'b1, 1'b1, 9'h005, 1'b1, 10'h004, 3'd2};
      stall_tab[9]  = '{1'b1, 1'b1, 9'h006, 1'b1, 10'h006, 3'd2};
      stall_tab[10] = '{1'b1, 1'b1, 9'h007, 1'b1, 10'h008, 3'd2};

      for (int i = 0; i < 512; i++) ram[i] = 64'(i);

      // ---- streaming from reset with out_ready = 1 ----
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 1'b0, 10'd0);
         chk_cycle($sformatf("stream%0d", k), 1'b1, 9'(k), k >= 2,
                   10'(2 * (k - 2)), (k >= 2) ? 3'd1 : 3'd0);
         next_cycle();
      end

      // ---- redirect to 0x0A5 with a read in flight ----
      drive(1'b1, 1'b1, 10'h0A5); chk_cycle("redir_n",  1'b0, 9'h000, 1'b1, 10'h010, 3'd1); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("redir_n1", 1'b1, 9'h052, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("redir_n2", 1'b1, 9'h053, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("redir_n3", 1'b1, 9'h054, 1'b1, 10'h0A4, 3'd1); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("redir_n4", 1'b1, 9'h055, 1'b1, 10'h0A6, 3'd1); next_cycle();

      // ---- back-to-back redirects: the last one wins ----
      drive(1'b1, 1'b1, 10'h200); chk_cycle("dbl_a",  1'b0, 9'h000, 1'b1, 10'h0A8, 3'd1); next_cycle();
      drive(1'b1, 1'b1, 10'h300); chk_cycle("dbl_b",  1'b0, 9'h000, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("dbl_n1", 1'b1, 9'h180, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("dbl_n2", 1'b1, 9'h181, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("dbl_n3", 1'b1, 9'h182, 1'b1, 10'h300, 3'd1); next_cycle();

      // ---- PC wrap at the top of the address space ----
      drive(1'b1, 1'b1, 10'h3FE); chk_cycle("wrap_n",  1'b0, 9'h000, 1'b1, 10'h302, 3'd1); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("wrap_n1", 1'b1, 9'h1FF, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("wrap_n2", 1'b1, 9'h000, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("wrap_n3", 1'b1, 9'h001, 1'b1, 10'h3FE, 3'd1); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("wrap_n4", 1'b1, 9'h002, 1'b1, 10'h000, 3'd1); next_cycle();

      // ---- asynchronous reset mid-burst, then the stall/drain table ----
      #2;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(stall_tab[i].rdy, 1'b0, 10'd0);
         chk_cycle($sformatf("stall%0d", i), stall_tab[i].en, stall_tab[i].addr,
                   stall_tab[i].v, stall_tab[i].pc, stall_tab[i].cnt);
         next_cycle();
      end

      // ---- redirect with a same-cycle pop while full ----
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, 10'd0);
         next_cycle();
      end
      drive(1'b1, 1'b1, 10'h100); chk_cycle("full_n",  1'b0, 9'h000, 1'b1, 10'h000, 3'd4); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("full_n1", 1'b1, 9'h080, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("full_n2", 1'b1, 9'h081, 1'b0, 10'h000, 3'd0); next_cycle();
      drive(1'b1, 1'b0, 10'h000); chk_cycle("full_n3", 1'b1, 9'h082, 1'b1, 10'h100, 3'd1); next_cycle();

      // ---- randomized phase against the PC-sequence model ----
      for (int i = 0; i < 512; i++) ram[i] = {$urandom, $urandom};
      do_reset();
      begin
         logic [9:0]  exp_pc;
         int          hs;
         int          since;
         logic        hold;
         logic [9:0]  hold_pc;
         logic [63:0] hold_b;
         exp_pc  = 10'd0;
         hs      = 0;
         since   = 100;
         hold    = 1'b0;
         hold_pc = '0;
         hold_b  = '0;
         for (int i = 0; i < 3000; i++) begin
            logic       rdy;
            logic       rv;
            logic [9:0] rpc;
            rdy = ($urandom_range(0, 99) < 70);
            rv  = ($urandom_range(0, 99) < 4);
            rpc = 10'($urandom);
            drive(rdy, rv, rpc);
            if (rv) chk("rnd_mem_en_redirect", mem_en, 0);
            if (since < 2) chk("rnd_flush_gap", out_valid, 0);
            if (since == 2) chk("rnd_refill_latency", out_valid, 1);
            if (hold) begin
               chk("rnd_hold_valid", out_valid, 1);
               chk("rnd_hold_pc", out_pc, hold_pc);
               chk("rnd_hold_bundle", out_bundle, hold_b);
            end
            chk("rnd_count_bound", (count <= 3'(DEPTH)), 1);
            if (out_valid && rdy) begin
               chk("rnd_out_pc", out_pc, exp_pc);
               chk("rnd_out_bundle", out_bundle, ram[exp_pc[9:1]]);
               exp_pc = exp_pc + 10'd2;
               hs++;
            end
            if (rv) begin
               exp_pc = rpc & 10'h3FE;
               since  = 0;
            end else if (since < 100) begin
               since++;
            end
            hold    = out_valid && !rdy && !rv;
            hold_pc = out_pc;
            hold_b  = out_bundle;
            next_cycle();
         end
         $display("random phase: %0d bundles accepted", hs);
         chk("rnd_progress", (hs > 500), 1);
`ifdef FETCHQ_STATS_EN
         chk("rnd_stat_bundles", stat_bundles, 64'(hs));
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
